uart_tx_queue: RTL and testbench

Transmit-side feeder sitting directly upstream of the uart top. It buffers bytes from game/keyboard logic in a FIFO and presents them one at a time on the uart's data_transmit/dte inputs. The uart exposes no tx-busy flag, so this block paces output by holding each byte stable for a full frame time before presenting the next. All logic runs on the system clock (clk), not the baud tick.

---
 rtl/uart_tx_queue.sv | 128 ++++++++++++
 tb/tb_uart_tx_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the uart transmitter. Each byte is held on data_transmit for one
// full frame slot: dte pulses for DTE_CYCLES, then the slot runs to FRAME_CYCLES.
module uart_tx_queue #(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int DTE_CYCLES   = 1400,
    parameter int FRAME_CYCLES = 114583
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    data_transmit,
    output logic          dte,
    output logic          busy
);

    localparam int CW = $clog2(FRAME_CYCLES + 1);
    localparam logic [CW-1:0] DTE_C   = CW'(DTE_CYCLES);
    localparam logic [CW-1:0] FRAME_C = CW'(FRAME_CYCLES);

    typedef enum logic [1:0] {IDLE, STROBE, HOLD} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      data_q, data_d;
    logic            dte_q, dte_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push, pop;

    assign full          = (count_q == (AW+1)'(DEPTH));
    assign empty         = (count_q == '0);
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign data_transmit = data_q;
    assign dte           = dte_q;
    assign busy          = (state_q != IDLE);

    // Pop is decided from registered occupancy, so a byte written this cycle waits one cycle.
    always_comb begin
        pop        = (state_q == IDLE) && !empty;
        push       = wr_en && (!full || pop);
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = overflow_q | (wr_en && full && !pop);
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dte_d   = dte_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pop) begin
                    data_d  = mem[rd_ptr_q];
                    dte_d   = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = STROBE;
                end
            end
            STROBE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == DTE_C) begin
                    dte_d   = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == FRAME_C) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                dte_d   = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            data_q     <= 8'h00;
            dte_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            data_q     <= data_d;
            dte_q      <= dte_d;
            cnt_q      <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue with short slot timing (DTE_CYCLES=4, FRAME_CYCLES=20).
// Tests push expected bytes; a negedge monitor pops them on every dte rise.
module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DTE   = 4;
    localparam int FRAME = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_en = 1'b0;
    logic        full, empty, overflow, dte, busy;
    logic [AW:0] count;
    logic [7:0]  data_transmit;

    logic [7:0]  exp_q[$];
    int          rise_t[$];
    int          rise_n = 0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    uart_tx_queue #(.DEPTH(DEPTH), .AW(AW), .DTE_CYCLES(DTE), .FRAME_CYCLES(FRAME)) dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .data_transmit(data_transmit), .dte(dte), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        exp_q.delete();
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy || !empty) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, (n < budget), 1);
    endtask

    task automatic wait_rises(input string name, input int target, input int budget);
        int n = 0;
        while (rise_n < target && n < budget) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, (n < budget), 1);
    endtask

    // Monitor: byte order, dte pulse width and busy slot length.
    initial begin : monitor
        logic prev_dte = 1'b0;
        logic prev_busy = 1'b0;
        int   hi_len = 0;
        int   busy_len = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_dte  = 1'b0;
                prev_busy = 1'b0;
                hi_len    = 0;
                busy_len  = 0;
            end else begin
                if (dte && !prev_dte) begin
                    rise_n++;
                    rise_t.push_back(cyc);
                    if (exp_q.size() == 0) check("unexpected_byte", {24'h0, data_transmit}, 32'hFFFF_FFFF);
                    else check("tx_byte", {24'h0, data_transmit}, {24'h0, exp_q.pop_front()});
                end
                if (dte) hi_len++;
                else if (prev_dte) begin
                    check("dte_width", hi_len, DTE);
                    hi_len = 0;
                end
                if (busy) busy_len++;
                else if (prev_busy) begin
                    check("busy_len", busy_len, FRAME);
                    busy_len = 0;
                end
                prev_dte  = dte;
                prev_busy = busy;
            end
        end
    end

    initial begin : stimulus
        int b;
        int r0;
        int n;

        // Reset then idle
        apply_reset();
        repeat (50) tick();
        check("rst_dte", dte, 0);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_data", data_transmit, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);

        // Single byte: visible in FIFO after capture, dte one edge later
        exp_q.push_back(8'h41);
        write_byte(8'h41);
        check("one_count", count, 1);
        check("one_empty0", empty, 0);
        check("one_dte0", dte, 0);
        tick();
        check("one_dte1", dte, 1);
        check("one_data", data_transmit, 8'h41);
        check("one_empty1", empty, 1);
        check("one_busy", busy, 1);
        wait_idle("one", 100);
        check("one_hold_data", data_transmit, 8'h41);

        // Three consecutive bytes: first pops as the second is written
        b = rise_t.size();
        exp_q.push_back(8'h41); exp_q.push_back(8'h30); exp_q.push_back(8'hA1);
        wr_en = 1'b1;
        wr_data = 8'h41; tick();
        wr_data = 8'h30; tick();
        wr_data = 8'hA1; tick();
        wr_en = 1'b0;
        check("three_count2", count, 2);
        wait_rises("three_r2", b + 2, 100);
        check("three_count1", count, 1);
        wait_rises("three_r3", b + 3, 100);
        check("three_count0", count, 0);
        wait_idle("three", 100);
        check("three_gap1", rise_t[b+1] - rise_t[b], FRAME + 1);
        check("three_gap2", rise_t[b+2] - rise_t[b+1], FRAME + 1);

        // Overflow: 17 writes queued behind a byte in flight; 0x10 dropped
        exp_q.push_back(8'hEE);
        write_byte(8'hEE);
        tick();
        wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'(i);
            if (i < 16) exp_q.push_back(8'(i));
            tick();
            if (i == 15) begin
                check("ovf_full_at16", full, 1);
                check("ovf_not_yet", overflow, 0);
            end
        end
        wr_en = 1'b0;
        check("ovf_count", count, 16);
        check("ovf_full", full, 1);
        check("ovf_flag", overflow, 1);
        wait_idle("ovf", 1000);
        check("ovf_sticky", overflow, 1);

        // Write while full in the same cycle as a pop; pointers wrap
        apply_reset();
        exp_q.push_back(8'h10);
        write_byte(8'h10);
        tick();
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'h20 + 8'(i);
            exp_q.push_back(8'h20 + 8'(i));
            tick();
        end
        wr_en = 1'b0;
        check("wrap_count_full", count, 16);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("wrap_wait_timeout", (n < 100), 1);
        wr_en   = 1'b1;
        wr_data = 8'h99;
        exp_q.push_back(8'h99);
        tick();
        wr_en = 1'b0;
        check("wrap_count", count, 16);
        check("wrap_full", full, 1);
        check("wrap_ovf", overflow, 0);
        check("wrap_dte", dte, 1);
        wait_idle("wrap", 1000);

        // Reset during HOLD with three bytes queued
        apply_reset();
        exp_q.push_back(8'h55);
        write_byte(8'h55);
        tick();
        wr_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        n = 0;
        while (dte && n < 50) begin
            tick();
            n++;
        end
        check("hold_wait_timeout", (n < 50), 1);
        check("hold_busy", busy, 1);
        check("hold_count", count, 3);
        reset = 1'b1;
        #1;
        check("mid_rst_dte", dte, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_empty", empty, 1);
        exp_q.delete();
        r0 = rise_n;
        tick(); tick();
        reset = 1'b0;
        repeat (50) tick();
        check("no_resend", rise_n, r0);
        check("post_rst_dte", dte, 0);
        exp_q.push_back(8'h66);
        write_byte(8'h66);
        wait_idle("post_rst", 100);
        check("post_rst_sent", rise_n, r0 + 1);

        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
